// File: rtl/prng_range_lemire_pkg.sv
// Shared types and constants for the Lemire bounded-range stage behind the xoshiro128++ core.
package prng_range_lemire_pkg;

  localparam int W = 32;
  localparam logic [W-1:0] RESET_BOUND  = '0;
  localparam logic [W-1:0] RESET_THRESH = '0;

  typedef enum logic [2:0] {
    ST_THRESH,
    ST_REQ,
    ST_CAP,
    ST_MUL,
    ST_CHK,
    ST_HOLD
  } state_t;

  // (2^W - bound) mod 2^W; only meaningful for bound != 0, where it equals 2^W - bound.
  function automatic logic [W-1:0] thresh_dividend(input logic [W-1:0] bound);
    return '0 - bound;
  endfunction

endpackage

// File: rtl/prng_range_lemire_serial_rem.sv
// Restoring remainder, one quotient bit per cycle; done is raised during the final iteration
// so the caller can latch the remainder on the same edge the last step completes.
module prng_serial_rem
  import prng_range_lemire_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [W-1:0] i_dividend,
  input  logic [W-1:0] i_divisor,
  output logic         o_done,
  output logic [W-1:0] o_rem
);

  localparam int CNT_W = $clog2(W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  logic [W-1:0]     r_dividend;
  logic [W-1:0]     r_divisor;
  logic [W-1:0]     r_rem;
  logic [CNT_W-1:0] r_cnt;
  logic             r_active;
  logic [W:0]       w_shift;
  logic [W:0]       w_diff;

  // A borrow out of the 33-bit subtraction means the trial subtract must be undone.
  always_comb begin
    w_shift = {r_rem, r_dividend[W-1]};
    w_diff  = w_shift - {1'b0, r_divisor};
  end

  assign o_rem  = w_diff[W] ? w_shift[W-1:0] : w_diff[W-1:0];
  assign o_done = r_active && (r_cnt == CNT_LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_dividend <= '0;
      r_divisor  <= '0;
      r_rem      <= '0;
      r_cnt      <= '0;
      r_active   <= 1'b0;
    end else if (i_start) begin
      r_dividend <= i_dividend;
      r_divisor  <= i_divisor;
      r_rem      <= '0;
      r_cnt      <= '0;
      r_active   <= 1'b1;
    end else if (r_active) begin
      r_rem      <= o_rem;
      r_dividend <= r_dividend << 1;
      r_cnt      <= r_cnt + 1'b1;
      if (o_done) begin
        r_active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/prng_range_lemire.sv
// Unbiased [0, bound) integers from a 32-bit PRNG stream using Lemire multiply-shift with
// rejection; serial shift-add multiplier and serial remainder keep the datapath small.
module prng_range_lemire
  import prng_range_lemire_pkg::*;
#(
  parameter int STEP_BITS = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic         i_bound_wr,
  input  logic [W-1:0] i_bound_data,
  output logic         o_gen_next,
  input  logic [W-1:0] i_gen_rnd,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [W-1:0] o_out_data,
  output logic         o_busy
);

  localparam int M = W / STEP_BITS;
  localparam logic [5:0] MCNT_LAST = 6'(M - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [W-1:0]     r_bound;
  logic [W-1:0]     r_thresh;
  logic [W-1:0]     r_x;
  logic [2*W-1:0]   r_acc;
  logic [2*W-1:0]   r_mcand;
  logic [5:0]       r_mcnt;
  logic             r_out_valid;
  logic [W-1:0]     r_out_data;
  logic [2*W-1:0]   w_pp;
  logic             w_gen_next;
  logic             w_transfer;
  logic             w_reject;
  logic             w_rem_start;
  logic             w_rem_done;
  logic [W-1:0]     w_rem;

  prng_serial_rem u_rem (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (w_rem_start),
    .i_dividend (thresh_dividend(i_bound_data)),
    .i_divisor  (i_bound_data),
    .o_done     (w_rem_done),
    .o_rem      (w_rem)
  );

  assign w_rem_start = i_bound_wr && (i_bound_data != '0);
  assign w_transfer  = r_out_valid && i_out_ready;
  assign w_reject    = r_acc[W-1:0] < r_thresh;

  // Partial product for the STEP_BITS multiplier digits currently at the bottom of x.
  always_comb begin
    w_pp = '0;
    for (int i = 0; i < STEP_BITS; i++) begin
      if (r_x[i]) begin
        w_pp = w_pp + (r_mcand << i);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_REQ;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A bound write overrides everything, including a transfer in the same cycle.
  always_comb begin
    w_state_next = r_state;
    w_gen_next   = 1'b0;
    if (i_bound_wr) begin
      w_state_next = (i_bound_data == '0) ? ST_REQ : ST_THRESH;
    end else begin
      case (r_state)
        ST_THRESH: if (w_rem_done) w_state_next = ST_REQ;
        ST_REQ: begin
          if (i_en) begin
            w_gen_next   = 1'b1;
            w_state_next = ST_CAP;
          end
        end
        ST_CAP:  w_state_next = (r_bound == '0) ? ST_HOLD : ST_MUL;
        ST_MUL:  if (r_mcnt == MCNT_LAST) w_state_next = ST_CHK;
        ST_CHK:  w_state_next = w_reject ? ST_REQ : ST_HOLD;
        ST_HOLD: if (w_transfer) w_state_next = ST_REQ;
        default: w_state_next = ST_REQ;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bound     <= RESET_BOUND;
      r_thresh    <= RESET_THRESH;
      r_x         <= '0;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mcnt      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (i_bound_wr) begin
      r_bound     <= i_bound_data;
      r_thresh    <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_THRESH: if (w_rem_done) r_thresh <= w_rem;
        ST_CAP: begin
          r_x <= i_gen_rnd;
          if (r_bound == '0) begin
            r_out_data  <= i_gen_rnd;
            r_out_valid <= 1'b1;
          end else begin
            r_acc   <= '0;
            r_mcand <= {{W{1'b0}}, r_bound};
            r_mcnt  <= '0;
          end
        end
        ST_MUL: begin
          r_acc   <= r_acc + w_pp;
          r_mcand <= r_mcand << STEP_BITS;
          r_x     <= r_x >> STEP_BITS;
          r_mcnt  <= r_mcnt + 1'b1;
        end
        ST_CHK: begin
          if (!w_reject) begin
            r_out_data  <= r_acc[2*W-1:W];
            r_out_valid <= 1'b1;
          end
        end
        ST_HOLD: if (w_transfer) r_out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  // Gated by reset so no request escapes while the state register is held in REQ.
  assign o_gen_next  = w_gen_next && !i_rst;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_busy      = (r_state == ST_THRESH);

endmodule
